// File: rtl/io_timer_if.sv
// CPU data-memory IO bus as seen by the io_timer block.
// The master drives address, data and strobes; the slave returns registered read data.
interface io_timer_if;
    logic [15:0] dMemIOAddress;
    logic [7:0]  dMemIOIn;
    logic        dMemIOWriteEn;
    logic        dMemIOReadEn;
    logic [7:0]  dMemIOOut;

    modport master (
        output dMemIOAddress,
        output dMemIOIn,
        output dMemIOWriteEn,
        output dMemIOReadEn,
        input  dMemIOOut
    );

    modport slave (
        input  dMemIOAddress,
        input  dMemIOIn,
        input  dMemIOWriteEn,
        input  dMemIOReadEn,
        output dMemIOOut
    );
endinterface

// File: rtl/io_timer.sv
// Memory-mapped 16-bit timer with prescaler, compare match and overflow flags.
// Define IO_TIMER_PWM_EN to add the registered pwm_out output.
module io_timer #(
    parameter logic [15:0] BASE_ADDR = 16'h1010
) (
    input  logic        clk,
    input  logic        reset,
    io_timer_if.slave   bus,
    output logic        interrupt,
    input  logic        interrupt_clr
`ifdef IO_TIMER_PWM_EN
    ,
    output logic        pwm_out
`endif
);

    logic [7:0]  ctrl_q, ctrl_d;
    logic        match_q, match_d;
    logic        ovf_q, ovf_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] cmp_q, cmp_d;
    logic [7:0]  shadow_q, shadow_d;
    logic [7:0]  hold_q, hold_d;
    logic [7:0]  presc_q, presc_d;
    logic [7:0]  rdata_q, rdata_d;

    logic [15:0] offset;
    logic        hit, wr, rd, tick, commit, cnt_eq, set_match, set_ovf;
    logic [7:0]  presc_top;

    always_comb begin
        offset    = bus.dMemIOAddress - BASE_ADDR;
        hit       = offset < 16'd6;
        wr        = bus.dMemIOWriteEn & hit;
        rd        = bus.dMemIOReadEn & hit;
        presc_top = 8'((9'd1 << ctrl_q[6:4]) - 9'd1);
        tick      = ctrl_q[0] && (presc_q == presc_top);
        commit    = wr && (offset == 16'd2);
        cnt_eq    = cnt_q == cmp_q;

        ctrl_d    = ctrl_q;
        cnt_d     = cnt_q;
        cmp_d     = cmp_q;
        shadow_d  = shadow_q;
        hold_d    = hold_q;
        set_match = 1'b0;
        set_ovf   = 1'b0;
        rdata_d   = 8'h00;

        if (!ctrl_q[0] || tick) presc_d = 8'h00;
        else                    presc_d = presc_q + 8'd1;

        // A CPU commit of CNT overrides any tick landing on the same edge.
        if (commit) begin
            cnt_d   = {hold_q, bus.dMemIOIn};
            presc_d = 8'h00;
        end else if (tick) begin
            set_match = cnt_eq;
            if (ctrl_q[1] && cnt_eq) begin
                cnt_d = 16'h0000;
            end else begin
                cnt_d   = cnt_q + 16'd1;
                set_ovf = cnt_q == 16'hFFFF;
            end
        end

        match_d = match_q;
        ovf_d   = ovf_q;
        if (wr && offset == 16'd1) begin
            if (bus.dMemIOIn[0]) match_d = 1'b0;
            if (bus.dMemIOIn[1]) ovf_d   = 1'b0;
        end
        if (interrupt_clr) match_d = 1'b0;
        if (set_match)     match_d = 1'b1;
        if (set_ovf)       ovf_d   = 1'b1;

        if (wr) begin
            case (offset[2:0])
                3'd0:    ctrl_d        = bus.dMemIOIn & 8'h77;
                3'd3:    hold_d        = bus.dMemIOIn;
                3'd4:    cmp_d[7:0]    = bus.dMemIOIn;
                3'd5:    cmp_d[15:8]   = bus.dMemIOIn;
                default: ;
            endcase
        end

        // Reads always see the state from before this edge's write.
        if (rd) begin
            case (offset[2:0])
                3'd0:    rdata_d = ctrl_q;
                3'd1:    rdata_d = {6'b0, ovf_q, match_q};
                3'd2: begin
                    rdata_d  = cnt_q[7:0];
                    shadow_d = cnt_q[15:8];
                end
                3'd3:    rdata_d = shadow_q;
                3'd4:    rdata_d = cmp_q[7:0];
                3'd5:    rdata_d = cmp_q[15:8];
                default: rdata_d = 8'h00;
            endcase
        end
    end

`ifdef IO_TIMER_PWM_EN
    logic pwm_q, pwm_d;

    always_comb begin
        pwm_d = ctrl_q[0] & (cnt_q < cmp_q);
    end

    assign pwm_out = pwm_q;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_q   <= 8'h00;
            match_q  <= 1'b0;
            ovf_q    <= 1'b0;
            cnt_q    <= 16'h0000;
            cmp_q    <= 16'h0000;
            shadow_q <= 8'h00;
            hold_q   <= 8'h00;
            presc_q  <= 8'h00;
            rdata_q  <= 8'h00;
`ifdef IO_TIMER_PWM_EN
            pwm_q    <= 1'b0;
`endif
        end else begin
            ctrl_q   <= ctrl_d;
            match_q  <= match_d;
            ovf_q    <= ovf_d;
            cnt_q    <= cnt_d;
            cmp_q    <= cmp_d;
            shadow_q <= shadow_d;
            hold_q   <= hold_d;
            presc_q  <= presc_d;
            rdata_q  <= rdata_d;
`ifdef IO_TIMER_PWM_EN
            pwm_q    <= pwm_d;
`endif
        end
    end

    assign bus.dMemIOOut = rdata_q;
    assign interrupt     = match_q & ctrl_q[2];

endmodule

// File: tb/tb_io_timer.sv
// Randomised scoreboard bench for io_timer: a behavioural model predicts every
// read response and the interrupt level, and a monitor compares on each falling edge.
module tb_io_timer;
    localparam logic [15:0] BASE = 16'h1010;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic interrupt;
    logic interrupt_clr = 1'b0;
`ifdef IO_TIMER_PWM_EN
    logic pwm_out;
`endif

    io_timer_if bus_if();

    io_timer #(.BASE_ADDR(BASE)) dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus_if),
        .interrupt     (interrupt),
        .interrupt_clr (interrupt_clr)
`ifdef IO_TIMER_PWM_EN
        ,
        .pwm_out       (pwm_out)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    logic [7:0]  m_ctrl = 8'h00;
    logic        m_match = 1'b0;
    logic        m_ovf = 1'b0;
    logic [15:0] m_cnt = 16'h0000;
    logic [15:0] m_cmp = 16'h0000;
    logic [7:0]  m_shadow = 8'h00;
    logic [7:0]  m_hold = 8'h00;
    logic [7:0]  m_presc = 8'h00;
    logic        m_pwm = 1'b0;

    task automatic check_val(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Behavioural model of one clock edge, from the register-level rules.
    task automatic model_step();
        logic [15:0] off;
        logic [7:0]  din;
        logic [7:0]  rv;
        bit          hit, wr, rd, tick, set_m, set_o;
        int          period;
        off   = bus_if.dMemIOAddress - BASE;
        din   = bus_if.dMemIOIn;
        hit   = off < 16'd6;
        wr    = bus_if.dMemIOWriteEn && hit;
        rd    = bus_if.dMemIOReadEn && hit;
        rv    = 8'h00;
        set_m = 0;
        set_o = 0;
        if (rd) begin
            case (off)
                16'd0: rv = m_ctrl;
                16'd1: rv = {6'b0, m_ovf, m_match};
                16'd2: begin rv = m_cnt[7:0]; m_shadow = m_cnt[15:8]; end
                16'd3: rv = m_shadow;
                16'd4: rv = m_cmp[7:0];
                16'd5: rv = m_cmp[15:8];
                default: rv = 8'h00;
            endcase
        end
        exp_q.push_back(rv);
        m_pwm  = m_ctrl[0] && (m_cnt < m_cmp);
        period = 1 << m_ctrl[6:4];
        tick   = m_ctrl[0] && (int'(m_presc) == period - 1);
        if (!m_ctrl[0] || tick) m_presc = 8'h00;
        else                    m_presc = m_presc + 8'd1;
        if (wr && off == 16'd2) begin
            m_cnt   = {m_hold, din};
            m_presc = 8'h00;
        end else if (tick) begin
            if (m_cnt == m_cmp) set_m = 1;
            if (m_ctrl[1] && m_cnt == m_cmp) m_cnt = 16'h0000;
            else begin
                if (m_cnt == 16'hFFFF) set_o = 1;
                m_cnt = m_cnt + 16'd1;
            end
        end
        if (wr && off == 16'd1) begin
            if (din[0]) m_match = 1'b0;
            if (din[1]) m_ovf = 1'b0;
        end
        if (interrupt_clr) m_match = 1'b0;
        if (set_m) m_match = 1'b1;
        if (set_o) m_ovf = 1'b1;
        if (wr) begin
            case (off)
                16'd0: m_ctrl = din & 8'h77;
                16'd3: m_hold = din;
                16'd4: m_cmp[7:0] = din;
                16'd5: m_cmp[15:8] = din;
                default: ;
            endcase
        end
    endtask

    // Reference model tracks the DUT edge by edge, including asynchronous reset.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_ctrl = 8'h00; m_match = 1'b0; m_ovf = 1'b0; m_cnt = 16'h0000;
            m_cmp = 16'h0000; m_shadow = 8'h00; m_hold = 8'h00; m_presc = 8'h00;
            m_pwm = 1'b0;
            exp_q.delete();
        end else begin
            model_step();
        end
    end

    // Monitor compares the presented read data and interrupt every falling edge.
    always @(negedge clk) begin
        logic [7:0] e;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
        check_val("dMemIOOut", {8'h00, bus_if.dMemIOOut}, {8'h00, e});
        check_val("interrupt", {15'h0, interrupt}, {15'h0, m_match & m_ctrl[2]});
`ifdef IO_TIMER_PWM_EN
        check_val("pwm_out", {15'h0, pwm_out}, {15'h0, m_pwm});
`endif
    end

    task automatic apply_stimulus(input logic [15:0] addr, input logic [7:0] din,
                                  input logic we, input logic re, input logic clr);
        @(negedge clk);
        #1;
        bus_if.dMemIOAddress = addr;
        bus_if.dMemIOIn      = din;
        bus_if.dMemIOWriteEn = we;
        bus_if.dMemIOReadEn  = re;
        interrupt_clr        = clr;
    endtask

    task automatic write_reg(input logic [15:0] off, input logic [7:0] data);
        apply_stimulus(BASE + off, data, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic read_reg(input logic [15:0] off);
        apply_stimulus(BASE + off, 8'h00, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(16'h0000, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int seen;
        bus_if.dMemIOAddress = 16'h0000;
        bus_if.dMemIOIn      = 8'h00;
        bus_if.dMemIOWriteEn = 1'b0;
        bus_if.dMemIOReadEn  = 1'b0;
        repeat (3) @(negedge clk);
        #1 reset = 1'b1;

        $display("[TB] reset state");
        for (int r = 0; r < 6; r++) read_reg(16'(r));
        idle(2);

        $display("[TB] compare match with auto reload");
        write_reg(4, 8'h03);
        write_reg(5, 8'h00);
        write_reg(0, 8'h07);
        seen = 0;
        for (int i = 1; i <= 20; i++) begin
            idle(1);
            if (interrupt) begin seen = i; break; end
        end
        check_val("match_latency", 16'(seen), 16'd5);
        apply_stimulus(16'h0000, 8'h00, 1'b0, 1'b0, 1'b1);
        idle(1);
        check_val("irq_after_clr", {15'h0, interrupt}, 16'h0000);
        write_reg(1, 8'h01);
        idle(1);
        check_val("w1c_set_wins", {15'h0, interrupt}, 16'h0001);
        write_reg(1, 8'h03);
        read_reg(1);
        idle(2);

        $display("[TB] overflow wrap");
        write_reg(0, 8'h00);
        write_reg(1, 8'h03);
        write_reg(4, 8'h00);
        write_reg(5, 8'h80);
        write_reg(3, 8'hFF);
        write_reg(2, 8'hFE);
        write_reg(0, 8'h01);
        idle(2);
        read_reg(1);
        idle(1);
        check_val("ovf_status", {8'h00, bus_if.dMemIOOut}, 16'h0002);
        read_reg(2);
        read_reg(3);
        idle(2);

        $display("[TB] prescaled count and shadowed read");
        write_reg(0, 8'h00);
        write_reg(3, 8'h00);
        write_reg(2, 8'hFC);
        write_reg(0, 8'h31);
        for (int i = 0; i < 12; i++) begin
            read_reg(2);
            read_reg(3);
            idle(2);
        end

        $display("[TB] reset mid count");
        write_reg(0, 8'h00);
        write_reg(3, 8'h12);
        write_reg(2, 8'h34);
        write_reg(0, 8'h71);
        idle(3);
        read_reg(2);
        @(posedge clk);
        #1;
        check_val("cnt_before_reset", {8'h00, bus_if.dMemIOOut}, 16'h0034);
        reset = 1'b0;
        #1;
        check_val("out_in_reset", {8'h00, bus_if.dMemIOOut}, 16'h0000);
        check_val("irq_in_reset", {15'h0, interrupt}, 16'h0000);
        idle(2);
        @(negedge clk);
        #1 reset = 1'b1;
        idle(10);
        for (int r = 0; r < 6; r++) read_reg(16'(r));
        idle(2);

        $display("[TB] randomised traffic");
        for (int i = 0; i < 500; i++) begin
            logic [15:0] a;
            logic [7:0]  d;
            int          op;
            op = $urandom_range(0, 9);
            a  = BASE - 16'd1 + 16'($urandom_range(0, 7));
            d  = 8'($urandom);
            if (a == BASE && $urandom_range(0, 3) != 0) d[6:5] = 2'b00;
            if (a == BASE + 16'd5) d = 8'h00;
            if (a == BASE + 16'd4) d = 8'($urandom_range(0, 15));
            if (a == BASE + 16'd3 && $urandom_range(0, 1) == 0) d = 8'h00;
            apply_stimulus(a, d, op < 4, op >= 3 && op <= 6, $urandom_range(0, 7) == 0);
        end
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/io_timer.md
IO_TIMER -- requirements
Module: io_timer

Interface
REQ-001 Parameter BASE_ADDR, default 16'h1010, first of six consecutive IO-space byte addresses owned by the block.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 dMemIOAddress  input  16  bus address from CPU.
REQ-005 dMemIOIn  input  8  write data from CPU.
REQ-006 dMemIOWriteEn  input  1  write strobe, one cycle per write.
REQ-007 dMemIOReadEn  input  1  read strobe, one cycle per read.
REQ-008 dMemIOOut  output  8  registered read data; 8'h00 when not driving a read, so it can be OR-combined with other responders.
REQ-009 interrupt  output  1  level interrupt request to CPU.
REQ-010 interrupt_clr  input  1  one-cycle acknowledge pulse from CPU.

Function
REQ-011 Register map (offset from BASE_ADDR): 0 CTRL, 1 STATUS, 2 CNT_L, 3 CNT_H, 4 CMP_L, 5 CMP_H; other addresses ignored, read as 8'h00.
REQ-012 CTRL: bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN, bits[6:4] PS; bits 3,7 read 0, writes ignored.
REQ-013 STATUS: bit0 MATCH, bit1 OVF; write-1-to-clear; other bits read 0.
REQ-014 Read latency exactly one cycle: dMemIOOut valid in cycle after selected dMemIOReadEn, 8'h00 in every other cycle.
REQ-015 Write takes effect at the edge on which dMemIOWriteEn is sampled high.
REQ-016 Prescaler: 8-bit counter, increments every cycle while EN=1; tick when it equals 2^PS-1, then returns to 0; held at 0 while EN=0.
REQ-017 On tick: if CNT==CMP, set MATCH; then CNT <= 0 if AUTO_RELOAD and match, else CNT+1.
REQ-018 CNT 16'hFFFF incrementing wraps to 16'h0000 and sets OVF.
REQ-019 Reading CNT_L returns CNT[7:0] and snapshots CNT[15:8] into a shadow; reading CNT_H returns shadow.
REQ-020 Writing CNT_H loads a holding byte; writing CNT_L commits {holding, data} to CNT atomically and clears prescaler.
REQ-021 CMP_L/CMP_H written directly per byte; read back directly.
REQ-022 interrupt = MATCH & IRQ_EN, combinational from registered state.
REQ-023 interrupt_clr high clears MATCH.
REQ-024 Simultaneous set and clear of a flag (W1C or interrupt_clr) in one cycle: set wins.
REQ-025 CNT_L commit coincident with tick: write wins, no match or overflow evaluated that cycle.
REQ-026 Simultaneous dMemIOReadEn and dMemIOWriteEn: write performed, read returns pre-write value.

Reset
REQ-027 Reset low forces CTRL, STATUS, CNT, CMP, shadow, holding, prescaler, dMemIOOut to zero immediately; interrupt low.
REQ-028 Reset asserted mid-count discards count; after release, block idle until EN written.

Configuration
REQ-029 Macro IO_TIMER_PWM_EN defined: adds output pwm_out (1 bit), registered, = EN & (CNT < CMP), reset 0.
REQ-030 Macro IO_TIMER_PWM_EN undefined: pwm_out port and logic absent; all other behaviour identical.

Verification
REQ-031 Write CMP=16'h0003, CTRL=8'h07 (PS=0) -> MATCH set and interrupt high on 4th tick after enable; CNT returns to 0.
REQ-032 Assert interrupt_clr one cycle -> interrupt low next cycle; W1C of STATUS=8'h01 coincident with new match -> MATCH stays 1.
REQ-033 Write CNT_H=8'hFF, CNT_L=8'hFE, CTRL=8'h01 -> after 2 ticks CNT=16'h0000, STATUS=8'h02, interrupt stays low.
REQ-034 CTRL=8'h31 (PS=3) -> CNT increments every 8 cycles; read CNT_L then CNT_H across a low-byte carry returns a consistent 16-bit value.
REQ-035 Drop reset mid-count with CNT=16'h1234 -> all registers read 0, dMemIOOut 8'h00, interrupt low.
REQ-036 With IO_TIMER_PWM_EN, CMP=16'h0002, AUTO_RELOAD, EN -> pwm_out high 2 of every 3 ticks.
